// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//   Bundles the result handshakes from the integer ALU and the FPU, the
//   retire controls, and the register-file write port of writeback_arbiter.
//   Optional feature macro: WB_PENDING_EN (adds the 64-bit pending vector).
// Signals
//   alu_valid/alu_ready/alu_instruction/alu_result  ALU result handshake
//   fpu_valid/fpu_ready/fpu_instruction/fpu_result  FPU result handshake
//   wb_stall, flush                                 retire controls
//   instruction, write_data, RegWrite               register-file write port
//   fifo_count                                      buffer occupancy
//   pending (WB_PENDING_EN)                         {fp,rd} writes still queued
// Modports
//   master : the arbiter (drives readies and the write port)
//   slave  : the producers / register file side
interface writeback_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic            alu_ready;
  logic [31:0]     alu_instruction;
  logic [XLEN-1:0] alu_result;
  logic            fpu_valid;
  logic            fpu_ready;
  logic [31:0]     fpu_instruction;
  logic [XLEN-1:0] fpu_result;
  logic            wb_stall;
  logic            flush;
  logic [31:0]     instruction;
  logic [XLEN-1:0] write_data;
  logic            RegWrite;
  logic [CW-1:0]   fifo_count;
`ifdef WB_PENDING_EN
  logic [63:0]     pending;
`endif

`ifdef WB_PENDING_EN
  modport master (
    input  alu_valid, alu_instruction, alu_result,
    input  fpu_valid, fpu_instruction, fpu_result,
    input  wb_stall, flush,
    output alu_ready, fpu_ready,
    output instruction, write_data, RegWrite, fifo_count, pending
  );
  modport slave (
    output alu_valid, alu_instruction, alu_result,
    output fpu_valid, fpu_instruction, fpu_result,
    output wb_stall, flush,
    input  alu_ready, fpu_ready,
    input  instruction, write_data, RegWrite, fifo_count, pending
  );
`else
  modport master (
    input  alu_valid, alu_instruction, alu_result,
    input  fpu_valid, fpu_instruction, fpu_result,
    input  wb_stall, flush,
    output alu_ready, fpu_ready,
    output instruction, write_data, RegWrite, fifo_count
  );
  modport slave (
    output alu_valid, alu_instruction, alu_result,
    output fpu_valid, fpu_instruction, fpu_result,
    output wb_stall, flush,
    input  alu_ready, fpu_ready,
    input  instruction, write_data, RegWrite, fifo_count
  );
`endif
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Write-side master of the 64-entry register file (x0-x31, f0-f31).
//   Arbitrates completed results from the ALU and FPU (alternating on ties),
//   buffers them in a DEPTH-entry FIFO and retires at most one per cycle onto
//   the instruction / write_data / RegWrite port. rd = instruction[11:7];
//   opcode 7'b1010011 selects the FP bank. Writes to integer x0 still take a
//   retire slot but do not raise RegWrite.
//   Optional feature macro: WB_PENDING_EN (drives wb.pending).
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   wb     writeback_arbiter_if.master (handshakes, controls, write port)
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_arbiter_if.master  wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0]    OP_FP   = 7'b1010011;
  localparam logic [CW-1:0] FULL_CT = CW'(DEPTH);

  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            last_fpu_q;
  logic            regwrite_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] data_q;

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_data  [DEPTH];

  logic            pop, retire, space;
  logic            grant_alu, grant_fpu;
  logic            alu_ready_d, fpu_ready_d;
  logic            push_alu, push_fpu, push;
  logic [31:0]     push_instr;
  logic [XLEN-1:0] push_data;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_data;
  logic            head_writes;

  always_comb begin
    pop    = !wb.wb_stall && (count_q != '0);
    // flush overrides the pop that the ready equation still sees
    retire = pop && !wb.flush;
    space  = (count_q < FULL_CT) || pop;

    // On a tie the source that did not win last time is granted
    grant_alu = wb.alu_valid && (!wb.fpu_valid || last_fpu_q);
    grant_fpu = wb.fpu_valid && !grant_alu;

    alu_ready_d = grant_alu && !wb.flush && space;
    fpu_ready_d = grant_fpu && !wb.flush && space;

    push_alu = wb.alu_valid && alu_ready_d;
    push_fpu = wb.fpu_valid && fpu_ready_d;
    push     = push_alu || push_fpu;

    push_instr = push_fpu ? wb.fpu_instruction : wb.alu_instruction;
    push_data  = push_fpu ? wb.fpu_result      : wb.alu_result;

    head_instr  = mem_instr[rd_ptr_q];
    head_data   = mem_data[rd_ptr_q];
    // integer x0 retires silently; f0 is a real register
    head_writes = (head_instr[6:0] == OP_FP) || (head_instr[11:7] != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_fpu_q <= 1'b1;
      regwrite_q <= 1'b0;
      instr_q    <= '0;
      data_q     <= '0;
    end else if (wb.flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + PW'(1);
        last_fpu_q <= push_fpu;
      end
      if (retire) begin
        rd_ptr_q   <= rd_ptr_q + PW'(1);
        instr_q    <= head_instr;
        data_q     <= head_data;
        regwrite_q <= head_writes;
      end else begin
        regwrite_q <= 1'b0;
      end
      case ({push, retire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= push_instr;
      mem_data[wr_ptr_q]  <= push_data;
    end
  end

  assign wb.alu_ready   = alu_ready_d;
  assign wb.fpu_ready   = fpu_ready_d;
  assign wb.instruction = instr_q;
  assign wb.write_data  = data_q;
  assign wb.RegWrite    = regwrite_q;
  assign wb.fifo_count  = count_q;

`ifdef WB_PENDING_EN
  logic [63:0]   pending_d;
  logic [PW-1:0] offs;
  logic          ent_fp;
  logic [4:0]    ent_rd;

  // Entry i is occupied when its distance from the read pointer is below count
  always_comb begin
    pending_d = '0;
    offs      = '0;
    ent_fp    = 1'b0;
    ent_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs   = PW'(i) - rd_ptr_q;
      ent_fp = (mem_instr[i][6:0] == OP_FP);
      ent_rd = mem_instr[i][11:7];
      if (({1'b0, offs} < count_q) && (ent_fp || (ent_rd != 5'd0))) begin
        pending_d[{ent_fp, ent_rd}] = 1'b1;
      end
    end
  end

  assign wb.pending = pending_d;
`endif

endmodule
